// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder sequencer. Captures two WIDTH-bit operands and an
//   initial carry, then feeds them LSB-first, one bit per clock, through a
//   single full_adder. The inter-bit carry lives in a flip-flop and the
//   result is assembled in a shift register. A one-cycle done pulse marks
//   completion; sum/carryOut hold until the next completion.
//
//   Ports
//     clk       in   rising-edge clock
//     rstN      in   asynchronous active-low reset
//     start     in   begin an addition (sampled only while ready=1)
//     operandA  in   WIDTH-bit addend A, captured on the accepting edge
//     operandB  in   WIDTH-bit addend B, captured on the accepting edge
//     carryIn   in   initial carry, captured on the accepting edge
//     ready     out  high in IDLE
//     busy      out  high in RUN
//     done      out  one-cycle pulse in DONE
//     sum       out  registered WIDTH-bit result
//     carryOut  out  registered final carry
// ---------------------------------------------------------------------------

// Single-bit full adder used as the serial datapath element.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carryIn,
    output logic sum,
    output logic carryOut
);
    assign sum      = a ^ b ^ carryIn;
    assign carryOut = (a & b) | (carryIn & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             carryIn,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
);

    // Bit counter needs at least one bit even when WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] sh_a_q,   sh_a_d;
    logic [WIDTH-1:0] sh_b_q,   sh_b_d;
    logic [WIDTH-1:0] sh_s_q,   sh_s_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             ready_q,  ready_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sh_s_shift;

    full_adder u_fa (
        .a        (sh_a_q[0]),
        .b        (sh_b_q[0]),
        .carryIn  (carry_q),
        .sum      (fa_sum),
        .carryOut (fa_cout)
    );

    // Result shift register: new bit enters at the MSB so that after WIDTH
    // shifts the LSB-first stream lands in natural bit order.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign sh_s_shift = fa_sum;
        end else begin : g_shift_wn
            assign sh_s_shift = {fa_sum, sh_s_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        sh_s_d  = sh_s_q;
        carry_d = carry_q;
        count_d = count_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_a_d  = operandA;
                    sh_b_d  = operandB;
                    carry_d = carryIn;
                    count_d = '0;
                    state_d = ST_RUN;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ST_RUN: begin
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                sh_s_d  = sh_s_shift;
                carry_d = fa_cout;
                count_d = count_q + CW'(1);
                if (count_q == LAST_BIT) begin
                    // Publish the result including the bit computed this edge.
                    sum_d   = sh_s_shift;
                    cout_d  = fa_cout;
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Status outputs are registered alongside the state so they are a pure
    // function of the current state.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sh_s_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            sh_s_q  <= sh_s_d;
            carry_q <= carry_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign carryOut = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Drives a WIDTH=8 and a WIDTH=4 serial_adder. A timeline model (age of the
//   current operation in clock edges plus the arithmetic A+B+cin) predicts
//   every output each cycle; directed transactions pin the model with
//   hand-computed literals.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W8 = 8;
    localparam int W4 = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       ready8, busy8, done8, carry8;
    logic [7:0] sum8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       ready4, busy4, done4, carry4;
    logic [3:0] sum4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(W8)) dut8 (
        .clk(clk), .rstN(rst_n), .start(start8),
        .operandA(a8), .operandB(b8), .carryIn(cin8),
        .ready(ready8), .busy(busy8), .done(done8),
        .sum(sum8), .carryOut(carry8)
    );

    serial_adder #(.WIDTH(W4)) dut4 (
        .clk(clk), .rstN(rst_n), .start(start4),
        .operandA(a4), .operandB(b4), .carryIn(cin4),
        .ready(ready4), .busy(busy4), .done(done4),
        .sum(sum4), .carryOut(carry4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // An operation accepted at edge E has age k after edge E+k. It is busy
    // for ages 0..W-1, signals done at age W, and the result becomes visible
    // at age W. Between operations (m_act=0) the unit is ready.
    logic       m8_act = 1'b0, m4_act = 1'b0;
    int         m8_age = 0,    m4_age = 0;
    logic [8:0] m8_res = '0,   m8_out = '0;
    logic [4:0] m4_res = '0,   m4_out = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_act <= 1'b0; m8_age <= 0; m8_res <= '0; m8_out <= '0;
        end else if (!m8_act && start8) begin
            m8_act <= 1'b1;
            m8_age <= 0;
            m8_res <= 9'(a8) + 9'(b8) + 9'(cin8);
        end else if (m8_act) begin
            m8_age <= m8_age + 1;
            if (m8_age == W8 - 1) m8_out <= m8_res;
            if (m8_age >= W8) m8_act <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4_act <= 1'b0; m4_age <= 0; m4_res <= '0; m4_out <= '0;
        end else if (!m4_act && start4) begin
            m4_act <= 1'b1;
            m4_age <= 0;
            m4_res <= 5'(a4) + 5'(b4) + 5'(cin4);
        end else if (m4_act) begin
            m4_age <= m4_age + 1;
            if (m4_age == W4 - 1) m4_out <= m4_res;
            if (m4_age >= W4) m4_act <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("w8_ready", 32'(ready8), 32'(!m8_act));
        chk("w8_busy",  32'(busy8),  32'(m8_act && m8_age < W8));
        chk("w8_done",  32'(done8),  32'(m8_act && m8_age == W8));
        chk("w8_sum",   32'({carry8, sum8}), 32'(m8_out));
        chk("w4_ready", 32'(ready4), 32'(!m4_act));
        chk("w4_busy",  32'(busy4),  32'(m4_act && m4_age < W4));
        chk("w4_done",  32'(done4),  32'(m4_act && m4_age == W4));
        chk("w4_sum",   32'({carry4, sum4}), 32'(m4_out));
        if (done8) $display("TXN w8 sum=%02h cout=%0d cyc=%0d", sum8, carry8, cyc);
        if (done4) $display("TXN w4 sum=%01h cout=%0d cyc=%0d", sum4, carry4, cyc);
    end

    // Directed WIDTH=8 transaction; called at a negedge with ready8=1.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec,
                        input logic [7:0] ps, input logic pc);
        int lat;
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        chk("run8_ready_drop", 32'(ready8), 32'd0);
        chk("run8_prev_hold", 32'({carry8, sum8}), 32'({pc, ps}));
        lat = 0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("run8_latency", 32'(lat), 32'd8);
        chk("run8_sum_lit", 32'(sum8), 32'(es));
        chk("run8_cout_lit", 32'(carry8), 32'(ec));
        @(negedge clk);
        chk("run8_done_pulse_end", 32'(done8), 32'd0);
        chk("run8_ready_back", 32'(ready8), 32'd1);
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int dones;
        int cnt;
        int last_acc;
        logic [8:0] cs;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready8), 32'd1);
        chk("rst_busy",  32'(busy8),  32'd0);
        chk("rst_done",  32'(done8),  32'd0);
        chk("rst_sum",   32'({carry8, sum8}), 32'd0);

        run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
        run8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 8'h00, 1'b1);
        run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 8'h7E, 1'b0);
        run8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 8'h00, 1'b1);

        // start pulses while busy / done must be ignored
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        dones = 0;
        cs = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done8) begin
                dones++;
                cs = {carry8, sum8};
            end
            if (k == 2 || k == 7 || k == 8) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
            end else begin
                start8 = 1'b0;
            end
            if (k == 4) a8 = 8'hEE;
        end
        start8 = 1'b0;
        chk("busy_done_count", 32'(dones), 32'd1);
        chk("busy_result", 32'(cs), 32'h030);
        $display("TXN busy-ignore dones=%0d result=%03h", dones, cs);

        // reset mid-operation
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h55; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_sum",   32'({carry8, sum8}), 32'd0);
        chk("abort_done",  32'(done8),  32'd0);
        chk("abort_ready", 32'(ready8), 32'd1);
        chk("abort_busy",  32'(busy8),  32'd0);
        $display("TXN reset-abort sum=%02h cout=%0d", sum8, carry8);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run8(8'h55, 8'h55, 1'b1, 8'hAB, 1'b0, 8'h00, 1'b0);

        // randomized traffic with starts arriving at any time
        repeat (400) begin
            @(negedge clk);
            start8 = ($urandom_range(0, 3) == 0);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        end
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // WIDTH=4 exhaustive, start held high for back-to-back operation
        last_acc = 0;
        for (int i = 0; i < 512; i++) begin
            cnt = 0;
            while (!ready4 && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 20) chk("w4_ready_timeout", 32'(cnt), 32'd0);
            start4 = 1'b1;
            a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8];
            if (i > 0) chk("w4_spacing", 32'(cyc - last_acc), 32'd6);
            last_acc = cyc;
            @(negedge clk);
        end
        start4 = 1'b0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
